pnr_source_switch_ctrl: RTL and testbench

//  Sequences changes of the PNR ADC role assignment (which ADC feeds trigger vs photon-number path).

---
 rtl/pnr_pkg.sv | 19 +
 rtl/pnr_down_counter.sv | 23 ++
 rtl/pnr_source_switch_ctrl.sv | 118 +++++++++++
 tb/tb_pnr_source_switch_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pnr_pkg.sv
// Shared types and width helpers for the PNR ADC role-switch sequencer.
package pnr_pkg;

   typedef enum logic [1:0] {
      PNR_SW_IDLE,
      PNR_SW_WAIT_QUIET,
      PNR_SW_BLANK
   } pnr_sw_state_e;

   // Width of a counter holding 0..n-1, never narrower than one bit.
   function automatic int unsigned pnr_cnt_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int unsigned PNR_QUIET_W   = pnr_cnt_w(16);
   localparam int unsigned PNR_SETTLE_W  = pnr_cnt_w(8);
   localparam int unsigned PNR_TIMEOUT_W = pnr_cnt_w(65535);

endpackage

// File: rtl/pnr_down_counter.sv
// Loadable down-counter with zero flag; holds at zero once reached.
module pnr_down_counter #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                cnt <= '0;
      else if (load)             cnt <= load_val;
      else if (en && cnt != '0)  cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/pnr_source_switch_ctrl.sv
// Applies CPU-requested ADC role changes only after PNR logic is quiet, then blanks while data settles.
// Optional forced switch after a wait timeout: define PNR_SWITCH_TIMEOUT_EN.
module pnr_source_switch_ctrl
   import pnr_pkg::*;
#(
   parameter int unsigned QUIET_CYC   = 16,
   parameter int unsigned SETTLE_CYC  = 8,
   parameter int unsigned TIMEOUT_CYC = 65535,
   parameter logic        RESET_SEL_A = 1'b1,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             adc_clk_i,
   input  logic             adc_rstn_i,
   input  logic             cfg_sel_a_i,
   input  logic             busy_i,
   output logic             sel_a_o,
   output logic             blank_o,
   output logic             pending_o,
   output logic             done_o,
   output logic             forced_o,
   input  logic             clr_i,
   output logic [CNT_W-1:0] switch_cnt_o
);

   localparam int unsigned QW = pnr_cnt_w(QUIET_CYC);
   localparam int unsigned SW = pnr_cnt_w(SETTLE_CYC);

   pnr_sw_state_e state;
   logic [QW-1:0] quiet_cnt;
   logic          mismatch, quiet_hit, timeout_hit, enter_blank, settle_zero;

   assign mismatch    = (cfg_sel_a_i != sel_a_o);
   assign quiet_hit   = (state == PNR_SW_WAIT_QUIET) && !busy_i && (quiet_cnt == QW'(QUIET_CYC - 1));
   assign enter_blank = (state == PNR_SW_WAIT_QUIET) && mismatch && (quiet_hit || timeout_hit);

   // Loaded with SETTLE_CYC-1 on the switching edge so blank_o spans exactly SETTLE_CYC cycles.
   pnr_down_counter #(.W(SW)) u_settle (
      .clk      (adc_clk_i),
      .rst_n    (adc_rstn_i),
      .load     (enter_blank),
      .load_val (SW'(SETTLE_CYC - 1)),
      .en       (state == PNR_SW_BLANK),
      .zero     (settle_zero)
   );

`ifdef PNR_SWITCH_TIMEOUT_EN
   localparam int unsigned TW = pnr_cnt_w(TIMEOUT_CYC);
   logic to_zero;

   pnr_down_counter #(.W(TW)) u_timeout (
      .clk      (adc_clk_i),
      .rst_n    (adc_rstn_i),
      .load     ((state == PNR_SW_IDLE) && mismatch),
      .load_val (TW'(TIMEOUT_CYC - 1)),
      .en       (state == PNR_SW_WAIT_QUIET),
      .zero     (to_zero)
   );

   assign timeout_hit = (state == PNR_SW_WAIT_QUIET) && to_zero;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYC == 0);
   assign timeout_hit    = 1'b0;
`endif

   always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
      if (!adc_rstn_i) begin
         state        <= PNR_SW_IDLE;
         quiet_cnt    <= '0;
         sel_a_o      <= RESET_SEL_A;
         blank_o      <= 1'b0;
         pending_o    <= 1'b0;
         done_o       <= 1'b0;
         forced_o     <= 1'b0;
         switch_cnt_o <= '0;
      end else begin
         done_o <= 1'b0;
         case (state)
            PNR_SW_IDLE: begin
               if (mismatch) begin
                  state     <= PNR_SW_WAIT_QUIET;
                  pending_o <= 1'b1;
                  quiet_cnt <= '0;
               end
            end
            PNR_SW_WAIT_QUIET: begin
               if (!mismatch) begin
                  state     <= PNR_SW_IDLE;
                  pending_o <= 1'b0;
               end else if (enter_blank) begin
                  state   <= PNR_SW_BLANK;
                  sel_a_o <= cfg_sel_a_i;
                  blank_o <= 1'b1;
                  if (!quiet_hit) forced_o <= 1'b1;
               end else begin
                  quiet_cnt <= busy_i ? '0 : quiet_cnt + 1'b1;
               end
            end
            PNR_SW_BLANK: begin
               if (settle_zero) begin
                  state     <= PNR_SW_IDLE;
                  blank_o   <= 1'b0;
                  pending_o <= 1'b0;
                  done_o    <= 1'b1;
                  if (switch_cnt_o != '1) switch_cnt_o <= switch_cnt_o + 1'b1;
               end
            end
            default: state <= PNR_SW_IDLE;
         endcase
         // Clear takes priority over a completion on the same edge.
         if (clr_i) begin
            forced_o     <= 1'b0;
            switch_cnt_o <= '0;
         end
      end
   end

endmodule

// File: tb/tb_pnr_source_switch_ctrl.sv
// Randomized scoreboard bench for pnr_source_switch_ctrl against a cycle-number reference model.
module tb_pnr_source_switch_ctrl;

   localparam int QUIET   = 16;
   localparam int SETTLE  = 8;
   localparam int TIMEOUT = 100;
   localparam int CNT_W   = 3;
   localparam int MAXC    = (1 << CNT_W) - 1;
`ifdef PNR_SWITCH_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b0, rstn = 1'b0, cfg = 1'b1, busy = 1'b0, clr = 1'b0;
   logic sel_a, blank, pending, done, forced;
   logic [CNT_W-1:0] cnt;

   pnr_source_switch_ctrl #(
      .QUIET_CYC(QUIET), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TIMEOUT),
      .RESET_SEL_A(1'b1), .CNT_W(CNT_W)
   ) dut (
      .adc_clk_i(clk), .adc_rstn_i(rstn), .cfg_sel_a_i(cfg), .busy_i(busy),
      .sel_a_o(sel_a), .blank_o(blank), .pending_o(pending), .done_o(done),
      .forced_o(forced), .clr_i(clr), .switch_cnt_o(cnt)
   );

   always #5 clk = ~clk;

   int vecs = 0, errs = 0;
   int cyc = 0, n_done = 0, last_done_cyc = -1;

   typedef struct { int sel; int cnt; } done_t;
   done_t exp_q[$];

   task automatic chk(input string nm, input int act, input int exp);
      vecs++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model: phases expressed as elapsed cycle counts, not hardware counters.
   int  m_sel = 1, m_blank = 0, m_pend = 0, m_forced = 0, m_cnt = 0;
   int  quiet_run = 0, waited = 0, blank_left = 0;

   always @(posedge clk) cyc++;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_sel = 1; m_blank = 0; m_pend = 0; m_forced = 0; m_cnt = 0;
         blank_left = 0; exp_q.delete();
      end else begin
         bit fin;
         fin = 1'b0;
         if (blank_left > 0) begin
            blank_left--;
            if (blank_left == 0) begin
               m_blank = 0; m_pend = 0; fin = 1'b1;
               m_cnt = (m_cnt < MAXC) ? m_cnt + 1 : MAXC;
            end
         end else if (m_pend) begin
            if (int'(cfg) == m_sel) m_pend = 0;
            else begin
               quiet_run = busy ? 0 : quiet_run + 1;
               waited++;
               if (quiet_run >= QUIET || (TO_EN && waited >= TIMEOUT)) begin
                  if (quiet_run < QUIET) m_forced = 1;
                  m_sel = int'(cfg); m_blank = 1; blank_left = SETTLE;
               end
            end
         end else if (int'(cfg) != m_sel) begin
            m_pend = 1; quiet_run = 0; waited = 0;
         end
         if (clr) begin m_forced = 0; m_cnt = 0; end
         if (fin) exp_q.push_back('{sel: m_sel, cnt: m_cnt});
      end
   end

   // Monitor: level outputs every cycle; done_o pulses pop the scoreboard.
   always @(negedge clk) begin
      chk("sel_a_o", int'(sel_a), m_sel);
      chk("blank_o", int'(blank), m_blank);
      chk("pending_o", int'(pending), m_pend);
      chk("forced_o", int'(forced), m_forced);
      chk("switch_cnt_o", int'(cnt), m_cnt);
      if (done) begin
         n_done++;
         last_done_cyc = cyc;
         if (exp_q.size() == 0) chk("done_unexpected", 1, 0);
         else begin
            done_t e;
            e = exp_q.pop_front();
            chk("done_sel", int'(sel_a), e.sel);
            chk("done_cnt", int'(cnt), e.cnt);
         end
      end else if (exp_q.size() != 0) begin
         chk("done_missing", 0, 1);
         exp_q.delete();
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int c0, input int lat, input string nm);
      int k;
      k = 0;
      while (last_done_cyc <= c0 && k < 300) begin step(1); k++; end
      chk(nm, last_done_cyc - c0, lat);
   endtask

   initial begin
      int c0, d0;
      step(3);
      rstn = 1'b1;

      // Idle with matching request: nothing may happen.
      d0 = n_done;
      for (int i = 0; i < 100; i++) begin busy = 1'($urandom_range(0, 1)); step(1); end
      busy = 1'b0;
      chk("idle_no_done", n_done, d0);
      chk("idle_sel", int'(sel_a), 1);

      // Plain switch 1->0 with busy low.
      cfg = 1'b0; c0 = cyc;
      wait_done(c0, 1 + QUIET + SETTLE, "latency_quiet");
      chk("cnt_first", int'(cnt), 1);
      step(3);

      // Busy pulses keep resetting the quiet window.
      cfg = 1'b1;
      for (int i = 0; i < 60; i++) begin busy = (i % 10 == 9); step(1); end
      chk("busy_hold_sel", int'(sel_a), 0);
      chk("busy_hold_pend", int'(pending), 1);
      busy = 1'b0; c0 = cyc;
      wait_done(c0, QUIET + SETTLE, "latency_after_busy");
      step(3);

      // Abort: request withdrawn during WAIT_QUIET.
      d0 = n_done;
      cfg = 1'b0; step(6);
      cfg = 1'b1; step(30);
      chk("abort_no_done", n_done, d0);
      chk("abort_sel", int'(sel_a), 1);
      chk("abort_cnt", int'(cnt), 2);

      if (TO_EN) begin
         busy = 1'b1; cfg = 1'b0; c0 = cyc;
         wait_done(c0, 1 + TIMEOUT + SETTLE, "latency_timeout");
         chk("forced_set", int'(forced), 1);
         clr = 1'b1; step(1); clr = 1'b0;
         chk("clr_forced", int'(forced), 0);
         chk("clr_cnt", int'(cnt), 0);
         busy = 1'b0; cfg = 1'b1; c0 = cyc;
         wait_done(c0, 1 + QUIET + SETTLE, "latency_restore");
         step(2);
      end

      // Reset in the middle of blanking.
      cfg = 1'b0; busy = 1'b0; step(20);
      chk("pre_rst_blank", int'(blank), 1);
      rstn = 1'b0; #1;
      chk("rst_sel", int'(sel_a), 1);
      chk("rst_blank", int'(blank), 0);
      chk("rst_pend", int'(pending), 0);
      chk("rst_cnt", int'(cnt), 0);
      step(2);
      cfg = 1'b1; rstn = 1'b1; step(2);

      // Random traffic, including counter saturation and clears.
      for (int i = 0; i < 3000; i++) begin
         busy = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 39) == 0) cfg = ~cfg;
         clr = ($urandom_range(0, 599) == 0);
         step(1);
      end
      clr = 1'b0; busy = 1'b0; cfg = sel_a;
      step(40);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
